char_line_buffer: RTL



---
 rtl/char_pkg.sv | 24 ++
 rtl/char_buf_ram.sv | 26 ++
 rtl/char_line_buffer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/char_pkg.sv
// Shared types, ASCII constants and character helpers for the line buffer.
package char_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic [7:0] ASCII_NUL     = 8'h00;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;

  function automatic logic is_term(input logic [7:0] c,
                                   input logic [7:0] term_a,
                                   input logic [7:0] term_b);
    return (c == term_a) || (c == term_b);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= ASCII_LOWER_A) && (c <= ASCII_LOWER_Z);
  endfunction

endpackage

// File: rtl/char_buf_ram.sv
// DEPTH x 8 character store: synchronous write, registered read with enable.
module char_buf_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // No reset on storage or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/char_line_buffer.sv
// Assembles upstream characters into lines and replays each line downstream.
// Optional LOWER_CHECK_EN adds a sticky lower_seen_o flag for leaked lower-case.
module char_line_buffer
  import char_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter logic [7:0]  TERM_A = ASCII_NUL,
  parameter logic [7:0]  TERM_B = ASCII_LF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  input  logic [7:0]  in_char_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [7:0]  out_char_o,
  output logic        out_last_o,
  input  logic        out_ready_i,
  output logic        line_done_o,
  output logic [AW:0] line_len_o,
`ifdef LOWER_CHECK_EN
  output logic        lower_seen_o,
`endif
  output logic        overflow_o
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   line_len_q, line_len_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          line_done_q, line_done_d;
  logic          overflow_q, overflow_d;
  logic          ram_we, ram_re;
  logic          accept, term, xfer;
`ifdef LOWER_CHECK_EN
  logic          lower_seen_q, lower_seen_d;
`endif

  char_buf_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_char_i),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_d),
    .rdata_o (out_char_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      line_len_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      line_done_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef LOWER_CHECK_EN
      lower_seen_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      line_len_q  <= line_len_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      line_done_q <= line_done_d;
      overflow_q  <= overflow_d;
`ifdef LOWER_CHECK_EN
      lower_seen_q <= lower_seen_d;
`endif
    end
  end

  // Next-state logic; the read port is primed one cycle ahead of out_valid.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    line_len_d  = line_len_q;
    line_done_d = 1'b0;
    overflow_d  = overflow_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    accept      = (state_q == FILL) && in_valid_i && in_ready_q;
    term        = is_term(in_char_i, TERM_A, TERM_B);
    xfer        = (state_q == DRAIN) && out_valid_q && out_ready_i;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (term) begin
            if (count_q != '0) begin
              state_d  = DRAIN;
              rd_ptr_d = '0;
              ram_re   = 1'b1;
            end else begin
              line_done_d = 1'b1;
              line_len_d  = '0;
            end
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + (AW+1)'(1);
            if (count_d == FULL) begin
              state_d    = DRAIN;
              overflow_d = 1'b1;
              rd_ptr_d   = '0;
              ram_re     = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (xfer) begin
          if (out_last_q) begin
            state_d     = FILL;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            line_done_d = 1'b1;
            line_len_d  = count_q;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            ram_re   = 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase

    in_ready_d  = (state_d == FILL) && (count_d < FULL);
    out_valid_d = (state_d == DRAIN);
    out_last_d  = (state_d == DRAIN) && ({1'b0, rd_ptr_d} == (count_d - (AW+1)'(1)));

`ifdef LOWER_CHECK_EN
    lower_seen_d = lower_seen_q || (accept && !term && is_lower(in_char_i));
`endif
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign line_done_o = line_done_q;
  assign line_len_o  = line_len_q;
  assign overflow_o  = overflow_q;
`ifdef LOWER_CHECK_EN
  assign lower_seen_o = lower_seen_q;
`endif

endmodule
